mips_seq_divider: RTL and testbench
===================================

Name: mips_seq_divider

Overview:
- Multi-cycle restoring divider for the MIPS datapath; executes DIVU, and DIV when the optional feature is enabled.
- The ALU adder/subtractor path is combinational; this block performs the inverse operation iteratively, one quotient bit per cycle.
- Results go to the HI (remainder) and LO (quotient) registers.
- Start/done handshake with the control unit, which stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand/result width in bits (≥ 4).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- is_signed  input  1  1 = DIV, 0 = DIVU; ignored unless SIGNED_DIV_EN.
- dividend  input  WIDTH  rs operand, captured when start is accepted.
- divisor  input  WIDTH  rt operand, captured when start is accepted.
- busy  output  1  high while the operation is in progress.
- done  output  1  one-cycle pulse when results are valid.
- quotient  output  WIDTH  LO value.
- remainder  output  WIDTH  HI value.
- div_by_zero  output  1  set with done when divisor was 0.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; counter=0.
- Reset asserted mid-operation aborts the operation at that edge; no done pulse is produced.
- States:
  - IDLE: start=1 latches operands and goes to BUSY; busy=1 from the next cycle.
  - BUSY: performs WIDTH iterations, then goes to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then returns to IDLE.
- Iteration (restoring division; the remainder register is WIDTH+1 bits internally):
  - Shift {rem, quo} left by 1, moving the dividend MSB into rem.
  - Trial = rem − divisor.
  - If trial ≥ 0: rem = trial and the quotient LSB = 1; otherwise the quotient LSB = 0.
- Latency: start accepted at edge N; done high in cycle N+WIDTH+1; results are valid on that same cycle.
- Output holding:
  - quotient and remainder hold their values until the next accepted start.
  - They are not cleared on return to IDLE.
- start is ignored in BUSY and DONE; the operation is not restarted and no error is raised.
- start held high continuously: a new operation begins on the first IDLE cycle after DONE.
- Divide by zero:
  - Detected at capture; the block skips the iterations and goes BUSY→DONE after 1 cycle.
  - Results: quotient = all ones, remainder = dividend, div_by_zero=1.
  - div_by_zero stays set until the next accepted start.
- Unsigned arithmetic only in the base build; no overflow is possible.
- Operands are not required to be stable after the accept cycle.

Optional Feature:
- Macro: SIGNED_DIV_EN.
- Defined, is_signed=1:
  - Operands are converted to magnitudes at capture.
  - The quotient is negated if the operand signs differ; the remainder takes the sign of the dividend (MIPS/C truncation).
  - Sign fix-up adds one extra cycle, so done appears in cycle N+WIDTH+2.
  - Most-negative ÷ −1: quotient = 0x80000000, remainder = 0.
  - Divide by zero behaves as in the base build, using the raw dividend.
- Defined, is_signed=0: identical to the base build, including latency.
- Not defined: is_signed is ignored; all divisions are unsigned; latency is fixed at WIDTH+1.

Test Plan:
- DIVU 100 ÷ 7, WIDTH=32 → done exactly 33 cycles after start; quotient=14, remainder=2, div_by_zero=0.
- DIVU 0xFFFFFFFF ÷ 1 → quotient=0xFFFFFFFF, remainder=0; busy high for 32 cycles.
- 25 ÷ 0 → done 2 cycles after start; quotient=0xFFFFFFFF, remainder=25, div_by_zero=1.
- Start pulsed again mid-operation (100 ÷ 7 running, 9 ÷ 3 presented) → first result still 14 r 2; no second done until a new start is issued in IDLE.
- Reset asserted at iteration 10 → next cycle busy=0, done=0, quotient=0, remainder=0; a following 9 ÷ 3 gives 3 r 0.
- SIGNED_DIV_EN, is_signed=1:
  - −7 ÷ 2 → quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1), done at start+34.
  - 0x80000000 ÷ −1 → quotient=0x80000000, remainder=0.

Source files
------------

// File: rtl/mips_seq_divider.sv
// Multi-cycle restoring divider for DIVU (and DIV when SIGNED_DIV_EN is defined).
// One quotient bit per cycle; HI = remainder, LO = quotient.
module mips_seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIXUP, S_DONE} state_t;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + ONE;
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? negate(v) : v;
  endfunction

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic             dz, sop, neg_q, neg_r;

  logic             cap_sop;
  logic [WIDTH-1:0] cap_dvd, cap_dvs;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] trial;

`ifdef SIGNED_DIV_EN
  assign cap_sop = is_signed;
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign cap_sop = 1'b0;
`endif

  assign cap_dvd = cap_sop ? magnitude(dividend) : dividend;
  assign cap_dvs = cap_sop ? magnitude(divisor)  : divisor;

  // Partial remainder is one bit wider than the operands after the shift;
  // once it fits, the difference always fits back into WIDTH bits.
  assign shifted = {rem, quo[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, dvs});
  assign trial   = shifted[WIDTH-1:0] - dvs;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_BUSY;
      S_BUSY: begin
        if (dz)               state_nxt = S_DONE;
        else if (cnt == LAST) state_nxt = sop ? S_FIXUP : S_DONE;
      end
      S_FIXUP: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dz    <= 1'b0;
      sop   <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt   <= '0;
            dvs   <= cap_dvs;
            sop   <= cap_sop;
            neg_q <= cap_sop & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= cap_sop & dividend[WIDTH-1];
            dz    <= (divisor == '0);
            // Divide by zero: results are final at capture, raw dividend kept.
            if (divisor == '0) begin
              quo <= '1;
              rem <= dividend;
            end else begin
              quo <= cap_dvd;
              rem <= '0;
            end
          end
        end
        S_BUSY: begin
          if (!dz) begin
            cnt <= cnt + CNT_W'(1);
            quo <= {quo[WIDTH-2:0], fits};
            rem <= fits ? trial : shifted[WIDTH-1:0];
          end
        end
        S_FIXUP: begin
          if (neg_q) quo <= negate(quo);
          if (neg_r) rem <= negate(rem);
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state == S_BUSY) || (state == S_FIXUP);
  assign done        = (state == S_DONE);
  assign quotient    = quo;
  assign remainder   = rem;
  assign div_by_zero = dz;

endmodule

// File: tb/tb_mips_seq_divider.sv
// Directed self-checking bench for mips_seq_divider (WIDTH=32).
module tb_mips_seq_divider;

  logic        clk = 1'b0;
  logic        reset, start, is_signed;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int errs   = 0;
  int checks = 0;

  mips_seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for done; returns number of edges waited.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Latency counts the accept edge as 1, so "done N cycles after start".
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sg, input int lat, input logic [31:0] eq,
                         input logic [31:0] er, input logic edz);
    int n, nb;
    @(negedge clk);
    dividend = a; divisor = b; is_signed = sg; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = ~a; divisor = ~b;
    n = 1; nb = 0;
    while (!done && n < 200) begin
      if (busy) nb++;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_busycyc"}, nb, lat - 1);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dz"}, div_by_zero, edz);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int n, nd;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dz", div_by_zero, 0);
    @(negedge clk) reset = 1'b0;

    run_div("divu_100_7", 32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2, 1'b0);
    run_div("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 33, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_div("div0", 32'd25, 32'd0, 1'b0, 2, 32'hFFFF_FFFF, 32'd25, 1'b1);
    repeat (3) @(posedge clk);
    #1 chk("div0_dz_held", div_by_zero, 1);
    chk("div0_q_held", quotient, 32'hFFFF_FFFF);

    // Start pulsed while busy must be ignored.
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (5) @(negedge clk);
    dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    @(negedge clk) start = 1'b0;
    #6;
    wait_done(n);
    chk("midstart_done_seen", done, 1);
    chk("midstart_q", quotient, 32'd14);
    chk("midstart_r", remainder, 32'd2);
    chk("midstart_dz_cleared", div_by_zero, 0);
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("midstart_no_2nd_done", nd, 0);
    chk("midstart_idle", busy, 0);

    // Reset in the middle of the iterations aborts the operation.
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    @(negedge clk) reset = 1'b0;
    run_div("after_abort_9_3", 32'd9, 32'd3, 1'b0, 33, 32'd3, 32'd0, 1'b0);
    repeat (4) @(posedge clk);
    #1 chk("hold_q", quotient, 32'd3);

    // Start held high: second operation begins on the first IDLE cycle.
    @(negedge clk);
    dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    dividend = 32'd20; divisor = 32'd6;
    wait_done(n);
    chk("held_first_lat", n + 1, 33);
    chk("held_first_q", quotient, 32'd3);
    @(posedge clk); #1;
    wait_done(n);
    start = 1'b0;
    chk("held_second_gap", n + 1, 34);
    chk("held_second_q", quotient, 32'd3);
    chk("held_second_r", remainder, 32'd2);
    repeat (3) @(posedge clk);

`ifdef SIGNED_DIV_EN
    run_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_div("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 34, 32'h8000_0000, 32'd0, 1'b0);
    run_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 34, 32'hFFFF_FFFD, 32'd1, 1'b0);
    run_div("div_m7_0", 32'hFFFF_FFF9, 32'd0, 1'b1, 2, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
    run_div("divu_in_signed_build", 32'hFFFF_FFF9, 32'd2, 1'b0, 33, 32'h7FFF_FFFC, 32'd1, 1'b0);
`else
    run_div("is_signed_ignored", 32'hFFFF_FFF9, 32'd2, 1'b1, 33, 32'h7FFF_FFFC, 32'd1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
